// File: rtl/gb_serial_pkg.sv
// Shared constants and state type for the GameBoy link-port controller.
package gb_serial_pkg;
   localparam logic [15:0] SB_ADDR       = 16'hFF01;
   localparam logic [15:0] SC_ADDR       = 16'hFF02;
   localparam int          SC_START_BIT  = 7;
   localparam int          SC_CLKSEL_BIT = 0;

   typedef enum logic {SER_IDLE = 1'b0, SER_ACTIVE = 1'b1} serial_state_t;
endpackage

// File: rtl/serial_edge_sync.sv
// Two-flop synchronizer with registered rise/fall pulses aligned to the synced level.
module serial_edge_sync #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);
   logic meta_q, sync_q, rise_q, fall_q;
   logic rise_d, fall_d;

   always_comb begin
      rise_d = meta_q & ~sync_q;
      fall_d = ~meta_q & sync_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign q    = sync_q;
   assign rise = rise_q;
   assign fall = fall_q;
endmodule

// File: rtl/gb_serial_link.sv
// GameBoy link port: SB/SC registers, 8-bit full-duplex shifter, serial IRQ.
module gb_serial_link
   import gb_serial_pkg::*;
#(
   parameter int CLK_DIV = 512
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] addr,
   input  logic        wr_en,
   input  logic [7:0]  wdata,
   output logic [7:0]  rdata,
   input  logic        sin,
   input  logic        sck_in,
   output logic        sout,
   output logic        sck_out,
   output logic        sck_oe,
   output logic        irq_serial
);
   localparam int HALF = CLK_DIV / 2;
   localparam int DW   = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(HALF - 1);

   serial_state_t state_q, state_d;
   logic [7:0]    sb_q, sb_d;
   logic [2:0]    cnt_q, cnt_d;
   logic [DW-1:0] div_q, div_d;
   logic          clksel_q, clksel_d;
   logic          act_clksel_q, act_clksel_d;
   logic          sck_q, sck_d;
   logic          sout_q, sout_d;
   logic          irq_q, irq_d;

   logic       sin_sync, sck_rise, sck_fall;
   logic       sck_lvl_unused;
   logic [1:0] sin_edge_unused;

   serial_edge_sync #(.RST_VAL(1'b1)) u_sck_sync (
      .clk(clk), .rst_n(rst), .d(sck_in),
      .q(sck_lvl_unused), .rise(sck_rise), .fall(sck_fall)
   );

   serial_edge_sync #(.RST_VAL(1'b1)) u_sin_sync (
      .clk(clk), .rst_n(rst), .d(sin),
      .q(sin_sync), .rise(sin_edge_unused[0]), .fall(sin_edge_unused[1])
   );

   logic sb_hit, sc_hit, sb_wr, sc_wr, active, div_tc;
   logic fall_ev, rise_ev, done, abort, start;

   always_comb begin
      sb_hit  = (addr == SB_ADDR);
      sc_hit  = (addr == SC_ADDR);
      sb_wr   = wr_en & sb_hit;
      sc_wr   = wr_en & sc_hit;
      active  = (state_q == SER_ACTIVE);
      div_tc  = (div_q == DIV_LAST);
      fall_ev = active & (act_clksel_q ? (div_tc & sck_q)  : sck_fall);
      rise_ev = active & (act_clksel_q ? (div_tc & ~sck_q) : sck_rise);
      done    = rise_ev & (cnt_q == 3'd7);
      abort   = sc_wr & ~wdata[SC_START_BIT] & active;
      // A start write landing on the completion cycle chains a new transfer.
      start   = sc_wr & wdata[SC_START_BIT] & (~active | done);
   end

   always_comb begin
      state_d      = state_q;
      sb_d         = sb_q;
      cnt_d        = cnt_q;
      div_d        = div_q;
      clksel_d     = clksel_q;
      act_clksel_d = act_clksel_q;
      sck_d        = sck_q;
      sout_d       = sout_q;
      irq_d        = 1'b0;

      if (sc_wr) clksel_d = wdata[SC_CLKSEL_BIT];
      if (sb_wr && !active) sb_d = wdata;

      if (active && act_clksel_q) begin
         div_d = div_tc ? '0 : div_q + DW'(1);
         if (div_tc) sck_d = ~sck_q;
      end

      if (fall_ev) sout_d = sb_q[7];
      if (rise_ev) begin
         sb_d  = {sb_q[6:0], sin_sync};
         cnt_d = cnt_q + 3'd1;
      end

      if (done) begin
         state_d = SER_IDLE;
         irq_d   = 1'b1;
         cnt_d   = '0;
         div_d   = '0;
      end

      if (start) begin
         state_d      = SER_ACTIVE;
         cnt_d        = '0;
         div_d        = '0;
         sck_d        = 1'b1;
         act_clksel_d = wdata[SC_CLKSEL_BIT];
      end

      // Abort freezes the shifter where it is and suppresses any completion.
      if (abort) begin
         state_d = SER_IDLE;
         sb_d    = sb_q;
         sout_d  = sout_q;
         cnt_d   = '0;
         div_d   = '0;
         sck_d   = 1'b1;
         irq_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= SER_IDLE;
         sb_q         <= 8'h00;
         cnt_q        <= '0;
         div_q        <= '0;
         clksel_q     <= 1'b0;
         act_clksel_q <= 1'b0;
         sck_q        <= 1'b1;
         sout_q       <= 1'b1;
         irq_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         sb_q         <= sb_d;
         cnt_q        <= cnt_d;
         div_q        <= div_d;
         clksel_q     <= clksel_d;
         act_clksel_q <= act_clksel_d;
         sck_q        <= sck_d;
         sout_q       <= sout_d;
         irq_q        <= irq_d;
      end
   end

   always_comb begin
      rdata = 8'hFF;
      if (sb_hit)      rdata = sb_q;
      else if (sc_hit) rdata = {(state_q == SER_ACTIVE), 6'b111111, clksel_q};
   end

   assign sout       = sout_q;
   assign sck_out    = sck_q;
   assign sck_oe     = (state_q == SER_ACTIVE) && act_clksel_q;
   assign irq_serial = irq_q;
endmodule

// File: tb/tb_gb_serial_link.sv
// Randomized self-checking bench for gb_serial_link against a byte-level transfer model.
module tb_gb_serial_link;
   localparam int          CLK_DIV = 8;
   localparam int          HALF    = CLK_DIV / 2;
   localparam int          XFER    = 8 * CLK_DIV;
   localparam logic [15:0] A_SB    = 16'hFF01;
   localparam logic [15:0] A_SC    = 16'hFF02;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] addr;
   logic        wr_en;
   logic [7:0]  wdata;
   logic [7:0]  rdata;
   logic        sin, sck_in;
   logic        sout, sck_out, sck_oe, irq_serial;

   int errors = 0;
   int checks = 0;

   gb_serial_link #(.CLK_DIV(CLK_DIV)) dut (
      .clk(clk), .rst(rst_n), .addr(addr), .wr_en(wr_en), .wdata(wdata),
      .rdata(rdata), .sin(sin), .sck_in(sck_in), .sout(sout),
      .sck_out(sck_out), .sck_oe(sck_oe), .irq_serial(irq_serial)
   );

   always #5 clk = ~clk;

   // Caller is at a negedge; the write is taken on the following posedge.
   task automatic write_reg(input logic [15:0] a, input logic [7:0] d);
      addr = a; wdata = d; wr_en = 1'b1;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic read_reg(input logic [15:0] a, output logic [7:0] d);
      addr = a;
      #1 d = rdata;
   endtask

   task automatic test_reset;
      logic [7:0] v;
      rst_n = 1'b0; wr_en = 1'b0; addr = 16'h0000; wdata = 8'h00; sin = 1'b1; sck_in = 1'b1;
      repeat (3) @(negedge clk);
      read_reg(A_SB, v); checks++;
      if (v !== 8'h00) begin errors++; $display("FAIL reset_sb: got %h want 00", v); end
      read_reg(A_SC, v); checks++;
      if (v !== 8'h7E) begin errors++; $display("FAIL reset_sc: got %h want 7e", v); end
      read_reg(16'hFF00, v); checks++;
      if (v !== 8'hFF) begin errors++; $display("FAIL reset_miss: got %h want ff", v); end
      checks++;
      if ({sout, sck_out, sck_oe, irq_serial} !== 4'b1100) begin
         errors++; $display("FAIL reset_pins: got %b want 1100", {sout, sck_out, sck_oe, irq_serial});
      end
      @(negedge clk); rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   // Model: sout is tx MSB-first on each sck fall, SB ends as rx, irq after XFER cycles.
   task automatic test_internal(input logic [7:0] tx, input logic [7:0] rx);
      logic [7:0] souts, v;
      int nfall, irq_at, nirq;
      logic prev_sck, oe_mid;
      sin = rx[7];
      repeat (4) @(negedge clk);
      write_reg(A_SB, tx);
      write_reg(A_SC, 8'h81);
      prev_sck = sck_out; nfall = 0; irq_at = -1; nirq = 0; souts = 8'h00; oe_mid = 1'b0;
      for (int k = 1; k <= XFER + 20; k++) begin
         @(negedge clk);
         if (prev_sck && !sck_out) begin
            if (nfall < 8) souts[7 - nfall] = sout;
            nfall++;
         end
         prev_sck = sck_out;
         if (k == 10) oe_mid = sck_oe;
         if (irq_serial) begin nirq++; if (irq_at < 0) irq_at = k; end
         if ((k % CLK_DIV) == HALF && k < XFER) sin = rx[7 - k / CLK_DIV];
      end
      checks++;
      if (nfall !== 8 || souts !== tx) begin
         errors++; $display("FAIL int_sout: got %h (%0d falls) want %h (8 falls)", souts, nfall, tx);
      end
      checks++;
      if (irq_at !== XFER || nirq !== 1) begin
         errors++; $display("FAIL int_irq: got cycle %0d count %0d want cycle %0d count 1", irq_at, nirq, XFER);
      end
      checks++;
      if (oe_mid !== 1'b1) begin errors++; $display("FAIL int_oe: got %b want 1", oe_mid); end
      read_reg(A_SB, v); checks++;
      if (v !== rx) begin errors++; $display("FAIL int_sb: got %h want %h", v, rx); end
      read_reg(A_SC, v); checks++;
      if (v !== 8'h7F) begin errors++; $display("FAIL int_sc: got %h want 7f", v); end
      checks++;
      if (sck_out !== 1'b1 || sck_oe !== 1'b0) begin
         errors++; $display("FAIL int_idle_pins: got sck %b oe %b want 1 0", sck_out, sck_oe);
      end
      @(negedge clk);
   endtask

   task automatic test_external(input logic [7:0] tx, input logic [7:0] rx);
      logic [7:0] souts, v;
      int nirq;
      logic oe_seen;
      sck_in = 1'b1; nirq = 0; oe_seen = 1'b0; souts = 8'h00;
      write_reg(A_SB, tx);
      write_reg(A_SC, 8'h80);
      for (int i = 0; i < 8; i++) begin
         sck_in = 1'b0; sin = rx[7 - i];
         repeat (10) begin
            @(negedge clk);
            oe_seen |= sck_oe;
            if (irq_serial) nirq++;
         end
         souts[7 - i] = sout;
         sck_in = 1'b1;
         repeat (10) begin
            @(negedge clk);
            oe_seen |= sck_oe;
            if (irq_serial) nirq++;
         end
      end
      repeat (10) begin @(negedge clk); if (irq_serial) nirq++; end
      read_reg(A_SB, v); checks++;
      if (v !== rx) begin errors++; $display("FAIL ext_sb: got %h want %h", v, rx); end
      checks++;
      if (souts !== tx) begin errors++; $display("FAIL ext_sout: got %h want %h", souts, tx); end
      checks++;
      if (nirq !== 1) begin errors++; $display("FAIL ext_irq: got %0d pulses want 1", nirq); end
      checks++;
      if (oe_seen !== 1'b0) begin errors++; $display("FAIL ext_oe: got %b want 0", oe_seen); end
      read_reg(A_SC, v); checks++;
      if (v !== 8'h7E) begin errors++; $display("FAIL ext_sc: got %h want 7e", v); end
      @(negedge clk);
   endtask

   task automatic test_ext_idle_and_hang;
      logic [7:0] v;
      int nirq;
      nirq = 0;
      write_reg(A_SB, 8'h5A);
      for (int i = 0; i < 4; i++) begin
         sck_in = 1'b0; sin = 1'($urandom_range(0, 1));
         repeat (6) @(negedge clk);
         sck_in = 1'b1;
         repeat (6) @(negedge clk);
      end
      read_reg(A_SB, v); checks++;
      if (v !== 8'h5A) begin errors++; $display("FAIL idle_edges_sb: got %h want 5a", v); end
      write_reg(A_SC, 8'h80);
      repeat (100) begin @(negedge clk); if (irq_serial) nirq++; end
      read_reg(A_SC, v); checks++;
      if (v !== 8'hFE) begin errors++; $display("FAIL ext_hang_sc: got %h want fe", v); end
      write_reg(A_SC, 8'h00);
      repeat (20) begin @(negedge clk); if (irq_serial) nirq++; end
      read_reg(A_SC, v); checks++;
      if (v !== 8'h7E) begin errors++; $display("FAIL ext_abort_sc: got %h want 7e", v); end
      checks++;
      if (nirq !== 0) begin errors++; $display("FAIL ext_hang_irq: got %0d pulses want 0", nirq); end
   endtask

   // Three bits of sin=0 are shifted into F0 before the abort at cycle 30.
   task automatic test_abort;
      logic [7:0] v;
      int nirq;
      nirq = 0; sin = 1'b0;
      repeat (4) @(negedge clk);
      write_reg(A_SB, 8'hF0);
      write_reg(A_SC, 8'h81);
      repeat (19) @(negedge clk);
      write_reg(A_SB, 8'h00);
      repeat (9) @(negedge clk);
      write_reg(A_SC, 8'h01);
      checks++;
      if (sck_out !== 1'b1 || sck_oe !== 1'b0) begin
         errors++; $display("FAIL abort_pins: got sck %b oe %b want 1 0", sck_out, sck_oe);
      end
      read_reg(A_SB, v); checks++;
      if (v !== 8'h80) begin errors++; $display("FAIL abort_sb: got %h want 80", v); end
      read_reg(A_SC, v); checks++;
      if (v !== 8'h7F) begin errors++; $display("FAIL abort_sc: got %h want 7f", v); end
      repeat (XFER + 20) begin @(negedge clk); if (irq_serial) nirq++; end
      checks++;
      if (nirq !== 0) begin errors++; $display("FAIL abort_irq: got %0d pulses want 0", nirq); end
   endtask

   task automatic test_back_to_back;
      logic [7:0] v, tx;
      int nirq, irq_at;
      tx = 8'($urandom); sin = 1'b0; nirq = 0; irq_at = -1;
      repeat (4) @(negedge clk);
      write_reg(A_SB, tx);
      write_reg(A_SC, 8'h81);
      repeat (XFER - 1) @(negedge clk);
      write_reg(A_SC, 8'h81);
      checks++;
      if (irq_serial !== 1'b1) begin errors++; $display("FAIL b2b_irq1: got %b want 1", irq_serial); end
      read_reg(A_SC, v); checks++;
      if (v !== 8'hFF) begin errors++; $display("FAIL b2b_sc: got %h want ff", v); end
      read_reg(A_SB, v); checks++;
      if (v !== 8'h00) begin errors++; $display("FAIL b2b_sb: got %h want 00", v); end
      for (int k = 1; k <= XFER + 20; k++) begin
         @(negedge clk);
         if (irq_serial) begin nirq++; if (irq_at < 0) irq_at = k; end
      end
      checks++;
      if (nirq !== 1 || irq_at !== XFER) begin
         errors++; $display("FAIL b2b_irq2: got cycle %0d count %0d want cycle %0d count 1", irq_at, nirq, XFER);
      end
   endtask

   task automatic test_reset_mid;
      logic [7:0] v;
      int nirq;
      nirq = 0;
      write_reg(A_SB, 8'($urandom));
      write_reg(A_SC, 8'h81);
      repeat (29) @(negedge clk);
      rst_n = 1'b0;
      #1 checks++;
      if ({sout, sck_out, sck_oe, irq_serial} !== 4'b1100) begin
         errors++; $display("FAIL rstmid_pins: got %b want 1100", {sout, sck_out, sck_oe, irq_serial});
      end
      read_reg(A_SB, v); checks++;
      if (v !== 8'h00) begin errors++; $display("FAIL rstmid_sb: got %h want 00", v); end
      read_reg(A_SC, v); checks++;
      if (v !== 8'h7E) begin errors++; $display("FAIL rstmid_sc: got %h want 7e", v); end
      @(negedge clk); rst_n = 1'b1;
      repeat (XFER + 20) begin @(negedge clk); if (irq_serial) nirq++; end
      checks++;
      if (nirq !== 0) begin errors++; $display("FAIL rstmid_irq: got %0d pulses want 0", nirq); end
   endtask

   initial begin
      test_reset;
      test_internal(8'hA5, 8'hFF);
      for (int i = 0; i < 3; i++) test_internal(8'($urandom), 8'($urandom));
      test_external(8'h3C, 8'h96);
      test_external(8'($urandom), 8'($urandom));
      test_ext_idle_and_hang;
      test_abort;
      test_back_to_back;
      test_reset_mid;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/gb_serial_link.md
Name: gb_serial_link

Overview:
- GameBoy link-port controller: memory-mapped SB (0xFF01) and SC (0xFF02) registers, an 8-bit full-duplex shift engine and the serial interrupt request.
- Acts as the transmitter end of the link (drives sout, and drives sck in internal-clock mode) and also as the receiver (samples sin).
- Sits on the CPU I/O bus beside the datapath; its interrupt pulse feeds the IF register logic.

Parameters:
- CLK_DIV, 512, system clocks per serial bit (4.194304 MHz / 8192 Hz); must be even and >= 4.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- addr  in  16  CPU bus address
- wr_en  in  1  write strobe, one cycle per write
- wdata  in  8  write data
- rdata  out  8  combinational read data; valid when addr hits SB/SC, else 8'hFF
- sin  in  1  serial data in
- sck_in  in  1  external serial clock
- sout  out  1  serial data out
- sck_out  out  1  serial clock out (internal mode)
- sck_oe  out  1  sck_out drive enable
- irq_serial  out  1  one-cycle interrupt pulse at transfer completion

Behaviour:
- Reset values: SB=8'h00, SC.start=0, SC.clksel=0, sout=1, sck_out=1, sck_oe=0, irq_serial=0, state=SER_IDLE, bit count=0, divider=0.
- Reads:
  - SB returns the shift register.
  - SC returns {start, 6'b111111, clksel}.
- Writes:
  - SB write in SER_IDLE loads the shift register. SB write in SER_ACTIVE is ignored.
  - SC write always stores clksel (wdata[0]). The new clksel takes effect only at the next transition to SER_ACTIVE.
  - SC write with wdata[7]=1 in SER_IDLE: enter SER_ACTIVE, clear bit count and divider, set start=1.
  - SC write with wdata[7]=1 in SER_ACTIVE: no further effect.
  - SC write with wdata[7]=0 in SER_ACTIVE: abort. Return to SER_IDLE, start=0, no irq, SB keeps its partially shifted value, sck_out=1.
- sck_oe = (state==SER_ACTIVE && active clksel==1).
- Internal clock mode:
  - The divider counts 0..CLK_DIV/2-1. At terminal count, sck_out toggles.
  - Falling edge (1->0): sout <= SB[7].
  - Rising edge (0->1): SB <= {SB[6:0], sin_sync}; bit count increments.
  - The first falling edge occurs CLK_DIV/2 cycles after the start write.
  - irq_serial pulses on the cycle after the 8th rising edge, exactly 8*CLK_DIV cycles after the start write. On that cycle: start=0, state=SER_IDLE, sout holds its value.
- External clock mode:
  - sck_in passes through a 2-flop synchronizer with edge detect.
  - Detected falling and rising edges perform the same falling/rising actions as internal mode.
  - No edges means the block stays SER_ACTIVE indefinitely (hardware-accurate).
  - Edges in SER_IDLE are ignored.
- sin always passes through a 2-flop synchronizer (sin_sync).
- Simultaneous events:
  - Completion and an SC start write in the same cycle: the completion irq fires and the new transfer starts (state stays SER_ACTIVE, start=1).
  - Completion and an SB write in the same cycle: the shift result wins.
  - Completion and an abort in the same cycle: the abort wins, no irq.
- Reset asserted mid-transfer: all state returns to reset values immediately. No irq is generated.

Decomposition:
- Shared package gb_serial_pkg holds:
  - SB_ADDR=16'hFF01, SC_ADDR=16'hFF02
  - SC_START_BIT=7, SC_CLKSEL_BIT=0
  - typedef enum logic {SER_IDLE, SER_ACTIVE} serial_state_t
- Sub-module serial_edge_sync: 2-flop synchronizer plus registered rise/fall pulse outputs. Instantiated for sck_in and sin (sin uses the synchronized level only).

Test Plan (CLK_DIV=8):
- Reset, then read SB and SC -> rdata 8'h00 and 8'h7E. sout=1, sck_oe=0, irq_serial=0.
- SB<=8'hA5, SC<=8'h81, sin held 1 -> sout sequence 1,0,1,0,0,1,0,1 on successive falling edges. irq pulses 64 cycles after the SC write. SB reads 8'hFF; SC reads 8'h7F.
- External mode: SB<=8'h3C, SC<=8'h80, drive 8 sck_in periods of 20 cycles with sin pattern 8'h96 MSB-first -> SB=8'h96, one irq pulse, sck_oe stays 0.
- Internal transfer of 8'hF0; at cycle 20 write SB<=8'h00 -> the SB write is ignored. At cycle 30 write SC<=8'h01 -> abort: no irq, start=0, sck_out=1, SB holds the partial shift.
- Write SC<=8'h81 on the exact completion cycle of a previous transfer -> one irq pulse; SC reads 8'hFF and a second transfer runs 64 more cycles.
- Assert rst low at cycle 30 of an internal transfer -> all outputs at reset values within the same cycle. No irq after release.
